mem_bus_responder: RTL

//  Memory-side responder for the multicycle controller's memRead/memWrite bus.

---
 rtl/mem_bus_responder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - memory-side responder: data RAM plus MMIO page (switches, LEDs, timer, output FIFO)
module mem_bus_responder #(
  parameter int WIDTH       = 16,
  parameter int RAM_DEPTH   = 1024,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic [WIDTH-1:0] memAdr,
  input  logic [WIDTH-1:0] memWriteData,
  output logic [WIDTH-1:0] memReadData,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] leds,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  input  logic             outReady
);

  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [WIDTH-1:0] RAM_TOP  = WIDTH'(RAM_DEPTH);
  localparam logic [WIDTH-1:0] ADR_SW   = {{(WIDTH-4){1'b1}}, 4'h0};
  localparam logic [WIDTH-1:0] ADR_LED  = {{(WIDTH-4){1'b1}}, 4'h1};
  localparam logic [WIDTH-1:0] ADR_TMR  = {{(WIDTH-4){1'b1}}, 4'h2};
  localparam logic [WIDTH-1:0] ADR_FIFO = {{(WIDTH-4){1'b1}}, 4'h3};
  localparam logic [WIDTH-1:0] ADR_STAT = {{(WIDTH-4){1'b1}}, 4'h4};
  localparam logic [CW-1:0]    FIFO_FULL_COUNT = CW'(FIFO_DEPTH);

  // Address decode
  logic sel_ram, sel_sw, sel_led, sel_tmr, sel_fifo, sel_stat;
  assign sel_ram  = (memAdr < RAM_TOP);
  assign sel_sw   = (memAdr == ADR_SW);
  assign sel_led  = (memAdr == ADR_LED);
  assign sel_tmr  = (memAdr == ADR_TMR);
  assign sel_fifo = (memAdr == ADR_FIFO);
  assign sel_stat = (memAdr == ADR_STAT);

  // State
  logic [WIDTH-1:0] ram [RAM_DEPTH];
  logic [WIDTH-1:0] sw_sync [SYNC_STAGES];
  logic [WIDTH-1:0] timer;
  logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow;

  // FIFO handshake; a pop frees a slot in the same cycle, so a full FIFO still takes a push
  logic fifo_full, fifo_empty, pop, push_req, push_ok, push_drop, stat_clear;
  assign fifo_full  = (count == FIFO_FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign outValid   = !fifo_empty;
  assign outData    = fifo_mem[rd_ptr];
  assign pop        = outValid && outReady;
  assign push_req   = memWrite && sel_fifo;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign push_drop  = push_req && fifo_full && !pop;
  assign stat_clear = memWrite && sel_stat;

  logic [WIDTH-1:0] stat_word;
  assign stat_word = {overflow, {(WIDTH-3-CW){1'b0}}, count, fifo_full, fifo_empty};

  // Read mux: values are those present during the strobe cycle, before the edge updates them
  logic [WIDTH-1:0] rd_value;
  always_comb begin
    rd_value = '0;
    if (sel_ram)       rd_value = ram[memAdr[AW-1:0]];
    else if (sel_sw)   rd_value = sw_sync[SYNC_STAGES-1];
    else if (sel_led)  rd_value = leds;
    else if (sel_tmr)  rd_value = timer;
    else if (sel_stat) rd_value = stat_word;
  end

  // Switch synchronizer chain
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
    end else begin
      sw_sync[0] <= switches;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
    end
  end

  // Data RAM write port; contents survive reset but a write coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (!reset && memWrite && sel_ram) ram[memAdr[AW-1:0]] <= memWriteData;
  end

  // Registered read data; a simultaneous write suppresses the read
  always_ff @(posedge clk) begin
    if (reset) memReadData <= '0;
    else if (memRead && !memWrite) memReadData <= rd_value;
  end

  // LED register
  always_ff @(posedge clk) begin
    if (reset) leds <= '0;
    else if (memWrite && sel_led) leds <= memWriteData;
  end

  // Free-running cycle timer; a write clears it and beats the increment
  always_ff @(posedge clk) begin
    if (reset) timer <= '0;
    else if (memWrite && sel_tmr) timer <= '0;
    else timer <= timer + 1'b1;
  end

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (!reset && push_ok) fifo_mem[wr_ptr] <= memWriteData;
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_drop)       overflow <= 1'b1;
      else if (stat_clear) overflow <= 1'b0;
    end
  end

endmodule
